// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control unit for the RISC-V shared-memory datapath. A Moore FSM
// steps each instruction through fetch, decode, execute, memory and
// writeback, reusing one ALU and one memory port.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   op, funct3, funct7b5 instruction fields from the instruction register
//   zero                ALU zero flag, used for branch resolution
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB                    datapath mux selects
//   ImmSrc, ALUControl  combinational decodes of the instruction fields
//   state               current FSM state, exposed for debug
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    ALUWB   = 4'd7,
    EXECI   = 4'd8,
    JAL     = 4'd9,
    BRANCH  = 4'd10
  } statetype;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  statetype cur;
  statetype nxt;
  statetype ostate;

  logic       irwrite_raw;
  logic       adrsrc_raw;
  logic       memwrite_raw;
  logic       regwrite_raw;
  logic       pcupdate;
  logic       branch;
  logic [1:0] aluop;

  assign state = cur;

  // State register: reset returns to FETCH on the next rising edge.
  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  // Next-state logic. Unreachable encodings fall back to FETCH.
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECR;
          OP_ITYPE:     nxt = EXECI;
          OP_BRANCH:    nxt = BRANCH;
          OP_JAL:       nxt = JAL;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMREAD : MEMWR;
      MEMREAD: nxt = MEMWB;
      MEMWB:   nxt = FETCH;
      MEMWR:   nxt = FETCH;
      EXECR:   nxt = ALUWB;
      ALUWB:   nxt = FETCH;
      EXECI:   nxt = ALUWB;
      JAL:     nxt = ALUWB;
      BRANCH:  nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  // While reset is held the mux selects already show the FETCH values, even
  // before the register has been cleared; the enables are masked below.
  assign ostate = reset ? FETCH : cur;

  // Per-state Moore outputs.
  always_comb begin
    irwrite_raw  = 1'b0;
    adrsrc_raw   = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    pcupdate     = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    case (ostate)
      FETCH: begin
        irwrite_raw = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        pcupdate    = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: adrsrc_raw = 1'b1;
      MEMWB: begin
        ResultSrc    = 2'b01;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        adrsrc_raw   = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      ALUWB: regwrite_raw = 1'b1;
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // funct3[0] distinguishes bne from beq, so it flips the sense of zero.
  assign PCWrite  = (pcupdate | (branch & (zero ^ funct3[0]))) & ~reset;
  assign IRWrite  = irwrite_raw  & ~reset;
  assign MemWrite = memwrite_raw & ~reset;
  assign RegWrite = regwrite_raw & ~reset;
  assign AdrSrc   = adrsrc_raw;

  // ALU decoder. Only R-type (op[5]=1) can request sub via funct7b5;
  // addi with a set bit 30 must still add.
  always_comb begin
    ALUControl = 3'b000;
    case (aluop)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format, from the opcode alone.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:     ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

endmodule
